// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: register indices and hazard sequencer states.
package cpu_pkg;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hz_state_t;

endpackage : cpu_pkg

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the LEGv8 front end: load-use, taken-branch and dmem-wait
// control, with saturating stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             br_taken_id,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_timeout_nxt;
  logic              load_use;
  logic              do_freeze;
  logic              do_run;

  // XZR is never a real producer, so it can never create a load-use hazard.
  assign load_use = ex_mem_read && (ex_rd != XZR_IDX) &&
                    ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= mem_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    mem_timeout_nxt = mem_timeout;
    do_freeze       = 1'b0;
    do_run          = 1'b0;
    pc_en           = 1'b1;
    if_id_en        = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    pipe_freeze     = 1'b0;

    case (state)
      RUN: begin
        if (dmem_busy) begin
          do_freeze    = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end else begin
          do_run = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_busy) begin
          do_freeze = 1'b1;
          if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            state_nxt       = TIMEOUT;
            mem_timeout_nxt = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          // Memory released: hazards on the held ID instruction are evaluated this cycle.
          do_run       = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      TIMEOUT: do_freeze = 1'b1;
      default: state_nxt = RUN;
    endcase

    if (do_freeze) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      pipe_freeze = 1'b1;
    end else if (do_run) begin
      if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end else if (br_taken_id) begin
        if_id_flush = 1'b1;
      end
    end

    // Reset cycle overrides everything: squash IF/ID and ID/EX, hold the PC.
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      pipe_freeze  = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (!pc_en),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (if_id_flush),
    .count (flush_count)
  );

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations (CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MAX_WAIT = 16;
  localparam int unsigned CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rn, id_rm, ex_rd;
  logic             id_uses_rn, id_uses_rm, ex_mem_read, br_taken_id, dmem_busy;
  logic             pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rn   (id_uses_rn),
    .id_uses_rm   (id_uses_rm),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .br_taken_id  (br_taken_id),
    .dmem_busy    (dmem_busy),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .pipe_freeze  (pipe_freeze),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .mem_timeout  (mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic pc, input logic ifid, input logic fl,
                         input logic bub, input logic frz);
    check({tag, ".pc_en"},        32'(pc_en),        32'(pc));
    check({tag, ".if_id_en"},     32'(if_id_en),     32'(ifid));
    check({tag, ".if_id_flush"},  32'(if_id_flush),  32'(fl));
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(bub));
    check({tag, ".pipe_freeze"},  32'(pipe_freeze),  32'(frz));
  endtask

  task automatic chk_cnt(input string tag, input int stl, input int fls);
    check({tag, ".stall_count"}, 32'(stall_count), 32'(stl));
    check({tag, ".flush_count"}, 32'(flush_count), 32'(fls));
  endtask

  task automatic idle();
    id_rn       = 5'd0;
    id_rm       = 5'd0;
    id_uses_rn  = 1'b0;
    id_uses_rm  = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    br_taken_id = 1'b0;
    dmem_busy   = 1'b0;
  endtask

  task automatic load_use_rn3();
    ex_mem_read = 1'b1;
    ex_rd       = 5'd3;
    id_rn       = 5'd3;
    id_uses_rn  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b0;
    #3 chk_ctl("rst0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk_cnt("rst1", 0, 0);
    check("rst1.mem_timeout", 32'(mem_timeout), 32'd0);
    chk_ctl("rst1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    #2 chk_ctl("run0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("run0", 0, 0);
    step();

    // Load-use on Rn: single stall with bubble, then EX no longer a load.
    load_use_rn3();
    #2 chk_ctl("lu_rn", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_cnt("lu_rn", 1, 0);
    ex_mem_read = 1'b0;
    #2 chk_ctl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; id_uses_rm = 1'b1;
    #2 chk_ctl("lu_rm", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_cnt("lu_rm", 2, 0);

    id_uses_rm = 1'b0;
    #2 chk_ctl("rm_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd31; id_rn = 5'd31; id_uses_rn = 1'b1;
    id_rm = 5'd31; id_uses_rm = 1'b1;
    #2 chk_ctl("xzr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    idle();
    ex_rd = 5'd3; id_rn = 5'd3; id_uses_rn = 1'b1;
    #2 chk_ctl("nonload", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_cnt("nonload", 2, 0);

    // Taken branch: one squashed slot, PC keeps advancing.
    idle();
    br_taken_id = 1'b1;
    #2 chk_ctl("br", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_cnt("br", 2, 1);
    idle();
    #2 chk_ctl("br_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // Load-use beats branch.
    load_use_rn3();
    br_taken_id = 1'b1;
    #2 chk_ctl("lu_br", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_cnt("lu_br", 3, 1);

    // dmem wait masks hazards; load-use re-presents once memory is ready.
    dmem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2 chk_ctl($sformatf("busy5_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    chk_cnt("busy5", 8, 1);
    dmem_busy = 1'b0;
    br_taken_id = 1'b0;
    #2 chk_ctl("busy5_lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk_cnt("busy5_lu", 9, 1);
    idle();
    #2 chk_ctl("busy5_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();

    // Reset while in MEM_WAIT returns to RUN and clears counters.
    dmem_busy = 1'b1;
    step();
    step();
    reset = 1'b0;
    #2 chk_ctl("rst_wait", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    dmem_busy = 1'b0;
    #2 chk_ctl("rst_wait_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("rst_wait", 0, 0);
    step();

    // Exactly MAX_WAIT busy cycles: no timeout; stall_count saturates at 15.
    dmem_busy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      #2 chk_ctl($sformatf("w16_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check($sformatf("w16_%0d.stall_count", i), 32'(stall_count), 32'((i > 15) ? 15 : i));
      check($sformatf("w16_%0d.mem_timeout", i), 32'(mem_timeout), 32'd0);
    end
    dmem_busy = 1'b0;
    #2 chk_ctl("w16_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("w16_end.mem_timeout", 32'(mem_timeout), 32'd0);
    chk_cnt("w16_end", 15, 0);

    // MAX_WAIT+1 busy cycles: timeout sets and freeze persists regardless of inputs.
    dmem_busy = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      #2 chk_ctl($sformatf("w17_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check($sformatf("w17_%0d.mem_timeout", i), 32'(mem_timeout), 32'((i == 17) ? 1 : 0));
    end
    idle();
    load_use_rn3();
    br_taken_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 chk_ctl($sformatf("tmo_%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("tmo_%0d.mem_timeout", i), 32'(mem_timeout), 32'd1);
      step();
    end
    chk_cnt("tmo", 15, 0);

    reset = 1'b0;
    #2 chk_ctl("tmo_rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    idle();
    #2 chk_ctl("tmo_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("tmo_rst.mem_timeout", 32'(mem_timeout), 32'd0);
    chk_cnt("tmo_rst", 0, 0);
    step();
    chk_cnt("final", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
